kb_ascii_decoder: RTL and testbench

- Sequential PS/2 keyboard front end between the ps2_rx byte receiver and the text/UI logic (Pong score entry, text console).
- Consumes scan-code set 2 bytes and parses make, break (F0) and extended (E0) sequences.
- Tracks Shift and Caps Lock. Translates make codes to case-correct ASCII.
- Buffers the resulting characters in a parametrised FIFO that the consumer reads with a pop strobe.

---
 rtl/kb_pkg.sv | 74 +++++++
 rtl/kb_ascii_decoder_if.sv | 22 ++
 rtl/kb_fifo.sv | 56 +++++
 rtl/kb_ascii_decoder.sv | 112 +++++++++++
 tb/tb_kb_ascii_decoder.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/kb_pkg.sv
// Shared constants, parser state type and the scan-code set 2 to ASCII table
// used by the PS/2 keyboard decoder.
package kb_pkg;

    localparam logic [7:0] BRK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE = 8'hE0;
    localparam logic [7:0] LSHIFT   = 8'h12;
    localparam logic [7:0] RSHIFT   = 8'h59;
    localparam logic [7:0] CAPS     = 8'h58;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } kb_state_t;

    // Returns {valid, ascii}. Letters follow 'upper'; digits and symbols follow 'shift'.
    function automatic logic [8:0] scan2ascii(input logic [7:0] code,
                                              input logic       upper,
                                              input logic       shift);
        logic [7:0] lc;
        logic [7:0] un;
        logic [7:0] sh;
        logic [8:0] res;
        lc  = 8'h00;
        un  = 8'h00;
        sh  = 8'h00;
        res = 9'h000;
        case (code)
            8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
            8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
            8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
            8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
            8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
            8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
            8'h35: lc = "y";  8'h1A: lc = "z";
            default: lc = 8'h00;
        endcase
        case (code)
            8'h45: begin un = "0"; sh = ")"; end
            8'h16: begin un = "1"; sh = "!"; end
            8'h1E: begin un = "2"; sh = "@"; end
            8'h26: begin un = "3"; sh = "#"; end
            8'h25: begin un = "4"; sh = "$"; end
            8'h2E: begin un = "5"; sh = "%"; end
            8'h36: begin un = "6"; sh = "^"; end
            8'h3D: begin un = "7"; sh = "&"; end
            8'h3E: begin un = "8"; sh = "*"; end
            8'h46: begin un = "9"; sh = "("; end
            8'h0E: begin un = 8'h60; sh = 8'h7E; end
            8'h4E: begin un = 8'h2D; sh = 8'h5F; end
            8'h55: begin un = 8'h3D; sh = 8'h2B; end
            8'h54: begin un = 8'h5B; sh = 8'h7B; end
            8'h5B: begin un = 8'h5D; sh = 8'h7D; end
            8'h5D: begin un = 8'h5C; sh = 8'h7C; end
            8'h4C: begin un = 8'h3B; sh = 8'h3A; end
            8'h52: begin un = 8'h27; sh = 8'h22; end
            8'h41: begin un = 8'h2C; sh = 8'h3C; end
            8'h49: begin un = 8'h2E; sh = 8'h3E; end
            8'h4A: begin un = 8'h2F; sh = 8'h3F; end
            8'h29: begin un = 8'h20; sh = 8'h20; end
            8'h5A: begin un = 8'h0D; sh = 8'h0D; end
            8'h66: begin un = 8'h08; sh = 8'h08; end
            default: begin un = 8'h00; sh = 8'h00; end
        endcase
        if (lc != 8'h00)
            res = {1'b1, upper ? (lc - 8'h20) : lc};
        else if (un != 8'h00)
            res = {1'b1, shift ? sh : un};
        return res;
    endfunction

endpackage

// File: rtl/kb_ascii_decoder_if.sv
// Byte-in / character-out bundle between ps2_rx, the decoder and its consumer.
interface kb_ascii_decoder_if;
    logic [7:0] scan_code;
    logic       scan_done_tick;
    logic       rd_ascii;
    logic [7:0] ascii_out;
    logic       empty;
    logic       full;
    logic       overflow_tick;
    logic       shift_on;
    logic       caps_on;

    modport slave (
        input  scan_code, scan_done_tick, rd_ascii,
        output ascii_out, empty, full, overflow_tick, shift_on, caps_on
    );

    modport master (
        output scan_code, scan_done_tick, rd_ascii,
        input  ascii_out, empty, full, overflow_tick, shift_on, caps_on
    );
endinterface

// File: rtl/kb_fifo.sv
// Character FIFO with wrap-bit pointers; head is visible combinationally,
// writes into a full FIFO are dropped and flagged with a one-cycle pulse.
module kb_fifo #(
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr,
    input  logic [7:0] wr_data,
    input  logic       rd,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic       overflow_tick
);
    localparam int             DEPTH   = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr_reg;
    logic [FIFO_AW:0] rd_ptr_reg;
    logic             overflow_reg;
    logic             rd_en;
    logic             wr_en;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[FIFO_AW] != rd_ptr_reg[FIFO_AW]) &&
                   (wr_ptr_reg[FIFO_AW-1:0] == rd_ptr_reg[FIFO_AW-1:0]);

    // A pop frees the slot being overwritten, so a full FIFO can accept a write alongside it.
    assign rd_en = rd && !empty;
    assign wr_en = wr && (!full || rd_en);

    assign rd_data       = empty ? 8'h00 : mem[rd_ptr_reg[FIFO_AW-1:0]];
    assign overflow_tick = overflow_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (rd_en)
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            overflow_reg <= wr && !wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg[FIFO_AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/kb_ascii_decoder.sv
// PS/2 set 2 front end: parses make/break/extended sequences, tracks Shift and
// Caps Lock, and queues the translated ASCII characters.
module kb_ascii_decoder
    import kb_pkg::*;
#(
    parameter int FIFO_AW = 2,
    parameter bit CAPS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    kb_ascii_decoder_if.slave kb
);
    kb_state_t  state_reg, state_next;
    logic       shift_l_reg, shift_l_next;
    logic       shift_r_reg, shift_r_next;
    logic       caps_reg, caps_next;
    logic       caps_held_reg, caps_held_next;
    logic       push;
    logic [8:0] mapped;
    logic [7:0] code;

    assign code        = kb.scan_code;
    assign kb.shift_on = shift_l_reg | shift_r_reg;
    assign kb.caps_on  = caps_reg;
    assign mapped      = scan2ascii(code, kb.shift_on ^ caps_reg, kb.shift_on);

    always_comb begin
        state_next     = state_reg;
        shift_l_next   = shift_l_reg;
        shift_r_next   = shift_r_reg;
        caps_next      = caps_reg;
        caps_held_next = caps_held_reg;
        push           = 1'b0;
        if (kb.scan_done_tick) begin
            case (state_reg)
                IDLE: begin
                    if (code == BRK_CODE)
                        state_next = BRK;
                    else if (code == EXT_CODE)
                        state_next = EXT;
                    else if (code == LSHIFT)
                        shift_l_next = 1'b1;
                    else if (code == RSHIFT)
                        shift_r_next = 1'b1;
                    else if (code == CAPS) begin
                        // Typematic repeats of a held Caps Lock must not toggle again.
                        if (CAPS_EN && !caps_held_reg) begin
                            caps_next      = ~caps_reg;
                            caps_held_next = 1'b1;
                        end
                    end else
                        push = mapped[8];
                end
                BRK: begin
                    if (code == BRK_CODE)
                        state_next = BRK;
                    else if (code == EXT_CODE)
                        state_next = EXT;
                    else begin
                        state_next = IDLE;
                        if (code == LSHIFT) shift_l_next = 1'b0;
                        if (code == RSHIFT) shift_r_next = 1'b0;
                        if (code == CAPS)   caps_held_next = 1'b0;
                    end
                end
                EXT: begin
                    state_next = (code == BRK_CODE) ? EXT_BRK : IDLE;
                end
                EXT_BRK: begin
                    if (code == BRK_CODE)
                        state_next = BRK;
                    else if (code == EXT_CODE)
                        state_next = EXT;
                    else
                        state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            shift_l_reg   <= 1'b0;
            shift_r_reg   <= 1'b0;
            caps_reg      <= 1'b0;
            caps_held_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shift_l_reg   <= shift_l_next;
            shift_r_reg   <= shift_r_next;
            caps_reg      <= caps_next;
            caps_held_reg <= caps_held_next;
        end
    end

    kb_fifo #(
        .FIFO_AW(FIFO_AW)
    ) u_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr           (push),
        .wr_data      (mapped[7:0]),
        .rd           (kb.rd_ascii),
        .rd_data      (kb.ascii_out),
        .empty        (kb.empty),
        .full         (kb.full),
        .overflow_tick(kb.overflow_tick)
    );

endmodule

// File: tb/tb_kb_ascii_decoder.sv
// Scenario bench for kb_ascii_decoder: expected characters are queued when the
// make code is sent and compared as the consumer pops them.
module tb_kb_ascii_decoder;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    kb_ascii_decoder_if bus();

    kb_ascii_decoder #(
        .FIFO_AW(2),
        .CAPS_EN(1'b1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .kb     (bus)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_c;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.scan_code      = b;
        bus.scan_done_tick = 1'b1;
        @(negedge clk);
        bus.scan_done_tick = 1'b0;
        $display("tx scan=%02h empty=%0b full=%0b head=%02h shift=%0b caps=%0b",
                 b, bus.empty, bus.full, bus.ascii_out, bus.shift_on, bus.caps_on);
    endtask

    task automatic pulse_rd();
        $display("pop head=%02h", bus.ascii_out);
        bus.rd_ascii = 1'b1;
        @(negedge clk);
        bus.rd_ascii = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", bus.full); end
        checks++; if (bus.overflow_tick !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", bus.overflow_tick); end
        checks++; if (bus.ascii_out !== 8'h00) begin errors++; $display("FAIL reset_ascii got=%02h exp=00", bus.ascii_out); end
        checks++; if (bus.shift_on !== 1'b0 || bus.caps_on !== 1'b0) begin errors++; $display("FAIL reset_mods got=%0b%0b exp=00", bus.shift_on, bus.caps_on); end
    endtask

    task automatic test_make_break();
        send_byte(8'h1C); exp_q.push_back(8'h61);
        checks++; if (bus.empty !== 1'b0 || bus.ascii_out !== 8'h61) begin errors++; $display("FAIL latency got=%0b/%02h exp=0/61", bus.empty, bus.ascii_out); end
        send_byte(8'hF0); send_byte(8'h1C);
        while (exp_q.size() != 0) begin
            exp_c = exp_q.pop_front();
            checks++; if (bus.empty !== 1'b0 || bus.ascii_out !== exp_c) begin errors++; $display("FAIL mb_char got=%0b/%02h exp=0/%02h", bus.empty, bus.ascii_out, exp_c); end
            pulse_rd();
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL mb_empty got=%0b exp=1", bus.empty); end
    endtask

    task automatic test_shift();
        send_byte(8'h12);
        checks++; if (bus.shift_on !== 1'b1) begin errors++; $display("FAIL shift_set got=%0b exp=1", bus.shift_on); end
        send_byte(8'h1C); exp_q.push_back(8'h41);
        send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h12);
        checks++; if (bus.shift_on !== 1'b0) begin errors++; $display("FAIL shift_clr got=%0b exp=0", bus.shift_on); end
        send_byte(8'h59);
        send_byte(8'h16); exp_q.push_back(8'h21);
        send_byte(8'h4E); exp_q.push_back(8'h5F);
        send_byte(8'h5D); exp_q.push_back(8'h7C);
        send_byte(8'hF0); send_byte(8'h59);
        checks++; if (bus.shift_on !== 1'b0) begin errors++; $display("FAIL rshift_clr got=%0b exp=0", bus.shift_on); end
        while (exp_q.size() != 0) begin
            exp_c = exp_q.pop_front();
            checks++; if (bus.empty !== 1'b0 || bus.ascii_out !== exp_c) begin errors++; $display("FAIL shift_char got=%0b/%02h exp=0/%02h", bus.empty, bus.ascii_out, exp_c); end
            pulse_rd();
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL shift_empty got=%0b exp=1", bus.empty); end
    endtask

    task automatic test_caps();
        send_byte(8'h58); send_byte(8'h58); send_byte(8'h58);
        send_byte(8'hF0); send_byte(8'h58);
        checks++; if (bus.caps_on !== 1'b1) begin errors++; $display("FAIL caps_on got=%0b exp=1", bus.caps_on); end
        send_byte(8'h1C); exp_q.push_back(8'h41);
        send_byte(8'h12);
        send_byte(8'h1C); exp_q.push_back(8'h61);
        send_byte(8'hF0); send_byte(8'h12);
        send_byte(8'h16); exp_q.push_back(8'h31);
        send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
        checks++; if (bus.caps_on !== 1'b0) begin errors++; $display("FAIL caps_off got=%0b exp=0", bus.caps_on); end
        while (exp_q.size() != 0) begin
            exp_c = exp_q.pop_front();
            checks++; if (bus.empty !== 1'b0 || bus.ascii_out !== exp_c) begin errors++; $display("FAIL caps_char got=%0b/%02h exp=0/%02h", bus.empty, bus.ascii_out, exp_c); end
            pulse_rd();
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL caps_empty got=%0b exp=1", bus.empty); end
    endtask

    task automatic test_extended();
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ext_nopush got=%0b exp=1", bus.empty); end
        send_byte(8'h29); exp_q.push_back(8'h20);
        send_byte(8'h05);
        send_byte(8'h5A); exp_q.push_back(8'h0D);
        send_byte(8'h66); exp_q.push_back(8'h08);
        while (exp_q.size() != 0) begin
            exp_c = exp_q.pop_front();
            checks++; if (bus.empty !== 1'b0 || bus.ascii_out !== exp_c) begin errors++; $display("FAIL ext_char got=%0b/%02h exp=0/%02h", bus.empty, bus.ascii_out, exp_c); end
            pulse_rd();
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ext_empty got=%0b exp=1", bus.empty); end
    endtask

    task automatic test_back_to_back();
        send_byte(8'h1C); exp_q.push_back(8'h61);
        send_byte(8'h32); exp_q.push_back(8'h62);
        send_byte(8'h21); exp_q.push_back(8'h63);
        send_byte(8'h23); exp_q.push_back(8'h64);
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fifo_full got=%0b exp=1", bus.full); end
        send_byte(8'h24);
        checks++; if (bus.overflow_tick !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%0b exp=1", bus.overflow_tick); end
        @(negedge clk);
        checks++; if (bus.overflow_tick !== 1'b0) begin errors++; $display("FAIL ovf_single got=%0b exp=0", bus.overflow_tick); end
        // simultaneous push and pop while full
        checks++; if (bus.ascii_out !== exp_q[0]) begin errors++; $display("FAIL pp_head got=%02h exp=%02h", bus.ascii_out, exp_q[0]); end
        bus.scan_code = 8'h2B; bus.scan_done_tick = 1'b1; bus.rd_ascii = 1'b1;
        @(negedge clk);
        bus.scan_done_tick = 1'b0; bus.rd_ascii = 1'b0;
        $display("tx scan=2B with pop, full=%0b head=%02h", bus.full, bus.ascii_out);
        void'(exp_q.pop_front()); exp_q.push_back(8'h66);
        checks++; if (bus.full !== 1'b1 || bus.overflow_tick !== 1'b0) begin errors++; $display("FAIL pp_full got=%0b/%0b exp=1/0", bus.full, bus.overflow_tick); end
        while (exp_q.size() != 0) begin
            exp_c = exp_q.pop_front();
            checks++; if (bus.empty !== 1'b0 || bus.ascii_out !== exp_c) begin errors++; $display("FAIL b2b_char got=%0b/%02h exp=0/%02h", bus.empty, bus.ascii_out, exp_c); end
            pulse_rd();
        end
        checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%0b/%0b exp=1/0", bus.empty, bus.full); end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
        send_byte(8'h1C);
        send_byte(8'hF0);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus.empty !== 1'b1 || bus.caps_on !== 1'b0) begin errors++; $display("FAIL mid_reset got=%0b/%0b exp=1/0", bus.empty, bus.caps_on); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        send_byte(8'h1C); exp_q.push_back(8'h61);
        while (exp_q.size() != 0) begin
            exp_c = exp_q.pop_front();
            checks++; if (bus.empty !== 1'b0 || bus.ascii_out !== exp_c) begin errors++; $display("FAIL rst_char got=%0b/%02h exp=0/%02h", bus.empty, bus.ascii_out, exp_c); end
            pulse_rd();
        end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%0b exp=1", bus.empty); end
    endtask

    initial begin
        bus.scan_code      = 8'h00;
        bus.scan_done_tick = 1'b0;
        bus.rd_ascii       = 1'b0;
        reset_n            = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_make_break();
        test_shift();
        test_caps();
        test_extended();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
